// File: rtl/whitening_tx.sv
// -----------------------------------------------------------------------------
// whitening_tx
//
// Transmit-side PN9 whitening serializer. Takes a frame byte by byte over a
// valid/ready handshake (length byte L, L payload bytes, two FCS bytes) and
// emits it LSB-first, one bit per clock, XORed with the x^9+x^5+1 sequence.
// Once a frame starts the output is gap-free. If the next byte is not ready
// when the current one has been shifted out, the frame is aborted with a
// one-cycle underrun pulse.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_data[7:0]   frame byte from the framer
//   in_valid       in_data valid
//   in_ready       block can accept a byte this cycle (combinational)
//   data_out       whitened serial bit (registered)
//   data_out_valid data_out valid; high for the whole frame (registered)
//   out_phase[1:0] phase of the current bit: 00 idle, 01 length, 10 payload,
//                  11 FCS (registered, aligned with data_out)
//   fsc_end        one-cycle pulse with the last bit of the frame (registered)
//   underrun       one-cycle pulse when a frame is aborted (registered)
// -----------------------------------------------------------------------------
module whitening_tx #(
    parameter logic [8:0] LFSR_SEED = 9'h1FF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       data_out,
    output logic       data_out_valid,
    output logic [1:0] out_phase,
    output logic       fsc_end,
    output logic       underrun
);

    // Encoding doubles as the out_phase code.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LEN     = 2'b01,
        PAYLOAD = 2'b10,
        FCS     = 2'b11
    } state_t;

    state_t     state, state_n;
    logic [7:0] hold, hold_n;
    logic       hold_v, hold_v_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [8:0] lfsr, lfsr_n, lfsr_adv;
    logic [8:0] to_accept, to_accept_n;    // frame bytes not yet accepted
    logic [8:0] bytes_left, bytes_left_n;  // frame bytes not yet loaded for output
    logic       data_out_n;
    logic       valid_n;
    logic       fsc_end_n;
    logic       underrun_n;
    logic       accept;
    logic       load;

    assign in_ready = ~hold_v & ((state == IDLE) | (to_accept != 9'd0));
    assign accept   = in_valid & in_ready;
    assign lfsr_adv = {lfsr[0] ^ lfsr[5], lfsr[8:1]};

    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n      = state;
        hold_n       = hold;
        hold_v_n     = hold_v;
        shift_n      = shift;
        bit_cnt_n    = bit_cnt;
        lfsr_n       = lfsr;
        to_accept_n  = to_accept;
        bytes_left_n = bytes_left;
        data_out_n   = 1'b0;
        fsc_end_n    = 1'b0;
        underrun_n   = 1'b0;
        load         = 1'b0;

        // Byte transfer from upstream. Only bytes after the length byte
        // count against to_accept.
        if (accept) begin
            hold_n   = in_data;
            hold_v_n = 1'b1;
            if (state != IDLE) begin
                to_accept_n = to_accept - 9'd1;
            end
        end

        case (state)
            IDLE: begin
                if (hold_v) begin
                    // The held byte is the length byte: L payload + 2 FCS follow.
                    load         = 1'b1;
                    state_n      = LEN;
                    bytes_left_n = {1'b0, hold} + 9'd2;
                    to_accept_n  = {1'b0, hold} + 9'd2;
                end
            end
            default: begin
                if (bit_cnt == 3'd7) begin
                    if (bytes_left == 9'd0) begin
                        state_n = IDLE;                    // normal frame end
                    end else if (hold_v) begin
                        load         = 1'b1;
                        state_n      = (bytes_left > 9'd2) ? PAYLOAD : FCS;
                        bytes_left_n = bytes_left - 9'd1;
                    end else begin
                        // Next byte missing: abort. A byte arriving on this
                        // same edge stays in hold and starts a new frame.
                        state_n     = IDLE;
                        to_accept_n = 9'd0;
                        underrun_n  = 1'b1;
                    end
                end else if ((state == FCS) && (bytes_left == 9'd0) && (bit_cnt == 3'd6)) begin
                    fsc_end_n = 1'b1;                      // coincides with the last bit
                end
            end
        endcase

        // Serializer and whitening. The LFSR always holds the mask for the
        // next bit to emit and sits at the seed whenever output is idle.
        if (load) begin
            hold_v_n   = 1'b0;
            shift_n    = hold;
            bit_cnt_n  = 3'd0;
            data_out_n = hold[0] ^ lfsr[0];
            lfsr_n     = lfsr_adv;
        end else if (state_n != IDLE) begin
            shift_n    = {shift[0], shift[7:1]};
            bit_cnt_n  = bit_cnt + 3'd1;
            data_out_n = shift[1] ^ lfsr[0];
            lfsr_n     = lfsr_adv;
        end else begin
            lfsr_n     = LFSR_SEED;
        end

        valid_n = (state_n != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            hold           <= 8'h00;
            hold_v         <= 1'b0;
            shift          <= 8'h00;
            bit_cnt        <= 3'd0;
            lfsr           <= LFSR_SEED;
            to_accept      <= 9'd0;
            bytes_left     <= 9'd0;
            data_out       <= 1'b0;
            data_out_valid <= 1'b0;
            out_phase      <= 2'b00;
            fsc_end        <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            state          <= state_n;
            hold           <= hold_n;
            hold_v         <= hold_v_n;
            shift          <= shift_n;
            bit_cnt        <= bit_cnt_n;
            lfsr           <= lfsr_n;
            to_accept      <= to_accept_n;
            bytes_left     <= bytes_left_n;
            data_out       <= data_out_n;
            data_out_valid <= valid_n;
            out_phase      <= state_n;
            fsc_end        <= fsc_end_n;
            underrun       <= underrun_n;
        end
    end

endmodule

// File: tb/tb_whitening_tx.sv
// -----------------------------------------------------------------------------
// tb_whitening_tx
//
// Directed bench for whitening_tx. Frames are pushed into tx_q and a driver
// presents them with in_valid held high while bytes remain. Every cycle's
// outputs are logged at the falling edge; the directed steps then compare the
// logs with hand-computed whitened bytes, phase patterns and pulse positions.
// The L=255 frame is checked against a bit-level PN9 reference.
// -----------------------------------------------------------------------------
module tb_whitening_tx;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       data_out;
    logic       data_out_valid;
    logic [1:0] out_phase;
    logic       fsc_end;
    logic       underrun;

    whitening_tx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .out_phase     (out_phase),
        .fsc_end       (fsc_end),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int accepted    = 0;

    logic [7:0] tx_q[$];
    logic       do_log[$];
    logic       dov_log[$];
    logic [1:0] ph_log[$];
    logic       fe_log[$];
    logic       ur_log[$];
    logic       rdy_log[$];
    logic       last_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        do_log.delete();
        dov_log.delete();
        ph_log.delete();
        fe_log.delete();
        ur_log.delete();
        rdy_log.delete();
        accepted = 0;
    endtask

    // One iteration per clock: retire the byte taken at the last rising edge,
    // log this cycle's outputs, then present the next byte.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (in_valid && last_rdy) begin
                void'(tx_q.pop_front());
                accepted++;
            end
            do_log.push_back(data_out);
            dov_log.push_back(data_out_valid);
            ph_log.push_back(out_phase);
            fe_log.push_back(fsc_end);
            ur_log.push_back(underrun);
            rdy_log.push_back(in_ready);
            last_rdy = in_ready;
            if (tx_q.size() > 0) begin
                in_valid = 1'b1;
                in_data  = tx_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
        end
    endtask

    function automatic int first_valid(input int from);
        for (int i = from; i < dov_log.size(); i++) begin
            if (dov_log[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    function automatic int run_len(input int s);
        int n;
        n = 0;
        if (s < 0) return 0;
        while ((s + n < dov_log.size()) && (dov_log[s + n] === 1'b1)) n++;
        return n;
    endfunction

    function automatic logic [7:0] get_byte(input int s, input int b);
        logic [7:0] r;
        r = 8'hxx;
        for (int i = 0; i < 8; i++) begin
            int k;
            k = s + 8 * b + i;
            if ((s >= 0) && (k < do_log.size())) r[i] = do_log[k];
        end
        return r;
    endfunction

    function automatic int count_fe();
        int n;
        n = 0;
        for (int i = 0; i < fe_log.size(); i++) if (fe_log[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_ur();
        int n;
        n = 0;
        for (int i = 0; i < ur_log.size(); i++) if (ur_log[i] === 1'b1) n++;
        return n;
    endfunction

    // Expected phase: 8 length bits, 8*L payload bits, 16 FCS bits.
    function automatic int phase_errs(input int s, input int len);
        int errs;
        logic [1:0] exp;
        errs = 0;
        for (int j = 0; j < 8 * (len + 3); j++) begin
            if (j < 8)                  exp = 2'b01;
            else if (j < 8 * (len + 1)) exp = 2'b10;
            else                        exp = 2'b11;
            if ((s < 0) || (s + j >= ph_log.size()) || (ph_log[s + j] !== exp)) errs++;
        end
        return errs;
    endfunction

    function automatic logic fe_at(input int i);
        if ((i < 0) || (i >= fe_log.size())) return 1'bx;
        return fe_log[i];
    endfunction

    function automatic logic ur_at(input int i);
        if ((i < 0) || (i >= ur_log.size())) return 1'bx;
        return ur_log[i];
    endfunction

    function automatic logic rdy_at(input int i);
        if ((i < 0) || (i >= rdy_log.size())) return 1'bx;
        return rdy_log[i];
    endfunction

    initial begin
        int         s;
        int         s2;
        int         errs;
        logic [7:0] frame[$];
        logic       exp_bits[$];
        logic [8:0] l;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_data_out", {31'd0, data_out}, 32'd0);
        check("rst_valid", {31'd0, data_out_valid}, 32'd0);
        check("rst_phase", {30'd0, out_phase}, 32'd0);
        check("rst_fsc_end", {31'd0, fsc_end}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- L=2 frame ----------------
        clear_logs();
        tx_q = '{8'h02, 8'h00, 8'h00, 8'hA5, 8'h5A};
        run(60);
        s = first_valid(0);
        check("l2_latency", s, 2);
        check("l2_len", run_len(s), 40);
        check("l2_b0", {24'd0, get_byte(s, 0)}, 32'hFD);
        check("l2_b1", {24'd0, get_byte(s, 1)}, 32'hE1);
        check("l2_b2", {24'd0, get_byte(s, 2)}, 32'h1D);
        check("l2_b3", {24'd0, get_byte(s, 3)}, 32'h3F);
        check("l2_b4", {24'd0, get_byte(s, 4)}, 32'hB7);
        check("l2_phase_errs", phase_errs(s, 2), 0);
        check("l2_fe_count", count_fe(), 1);
        check("l2_fe_pos", {31'd0, fe_at(s + 39)}, 32'd1);
        check("l2_ur_count", count_ur(), 0);

        // ---------------- L=0 frame ----------------
        clear_logs();
        tx_q = '{8'h00, 8'h12, 8'h34};
        run(40);
        s = first_valid(0);
        check("l0_len", run_len(s), 24);
        check("l0_b0", {24'd0, get_byte(s, 0)}, 32'hFF);
        check("l0_b1", {24'd0, get_byte(s, 1)}, 32'hF3);
        check("l0_b2", {24'd0, get_byte(s, 2)}, 32'h29);
        check("l0_phase_errs", phase_errs(s, 0), 0);
        check("l0_fe_pos", {31'd0, fe_at(s + 23)}, 32'd1);

        // ---------------- underrun: L=4, second payload byte withheld ----------------
        clear_logs();
        tx_q = '{8'h04, 8'h11};
        run(40);
        s = first_valid(0);
        check("ur_len", run_len(s), 16);
        check("ur_b0", {24'd0, get_byte(s, 0)}, 32'hFB);
        check("ur_b1", {24'd0, get_byte(s, 1)}, 32'hF0);
        check("ur_pulse_pos", {31'd0, ur_at(s + 16)}, 32'd1);
        check("ur_count", count_ur(), 1);
        check("ur_fe_count", count_fe(), 0);
        check("ur_ready_after", {31'd0, rdy_at(s + 20)}, 32'd1);
        clear_logs();
        tx_q = '{8'h01, 8'hC3, 8'hAA, 8'h55};
        run(45);
        s = first_valid(0);
        check("ur_next_len", run_len(s), 32);
        check("ur_next_b0", {24'd0, get_byte(s, 0)}, 32'hFE);
        check("ur_next_b1", {24'd0, get_byte(s, 1)}, 32'h22);

        // ---------------- back-to-back frames ----------------
        clear_logs();
        tx_q = '{8'h00, 8'h12, 8'h34, 8'h01, 8'hC3, 8'hAA, 8'h55};
        run(80);
        s = first_valid(0);
        check("b2b_len_a", run_len(s), 24);
        check("b2b_ready_at_fe", {31'd0, rdy_at(s + 23)}, 32'd0);
        check("b2b_ready_pre_fe", {31'd0, rdy_at(s + 20)}, 32'd0);
        s2 = first_valid(s + 24);
        check("b2b_gap", s2 - (s + 24), 2);
        check("b2b_len_b", run_len(s2), 32);
        check("b2b_b_b0", {24'd0, get_byte(s2, 0)}, 32'hFE);
        check("b2b_b_b3", {24'd0, get_byte(s2, 3)}, 32'hCF);
        check("b2b_fe_count", count_fe(), 2);

        // ---------------- reset during payload bit 3 ----------------
        clear_logs();
        tx_q = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        run(14);
        check("mid_valid_before", {31'd0, dov_log[13]}, 32'd1);
        check("mid_phase_before", {30'd0, ph_log[13]}, 32'd2);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tx_q.delete();
        last_rdy = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, data_out_valid}, 32'd0);
        check("mid_rst_phase", {30'd0, out_phase}, 32'd0);
        check("mid_rst_data", {31'd0, data_out}, 32'd0);
        check("mid_rst_fe", {31'd0, fsc_end}, 32'd0);
        check("mid_rst_ur", {31'd0, underrun}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        tx_q = '{8'h01, 8'hC3, 8'hAA, 8'h55};
        run(45);
        s = first_valid(0);
        check("post_rst_len", run_len(s), 32);
        check("post_rst_b0", {24'd0, get_byte(s, 0)}, 32'hFE);
        check("post_rst_b1", {24'd0, get_byte(s, 1)}, 32'h22);
        check("post_rst_b2", {24'd0, get_byte(s, 2)}, 32'hB7);
        check("post_rst_b3", {24'd0, get_byte(s, 3)}, 32'hCF);
        check("post_rst_ur", count_ur(), 0);

        // ---------------- L=255, random payload, bit-level PN9 reference ----------------
        frame.delete();
        frame.push_back(8'hFF);
        for (int i = 0; i < 257; i++) frame.push_back(8'($urandom_range(0, 255)));
        exp_bits.delete();
        l = 9'h1FF;
        for (int b = 0; b < frame.size(); b++) begin
            logic [7:0] byte_v;
            byte_v = frame[b];
            for (int i = 0; i < 8; i++) begin
                exp_bits.push_back(byte_v[i] ^ l[0]);
                l = {l[0] ^ l[5], l[8:1]};
            end
        end
        clear_logs();
        tx_q = frame;
        run(2100);
        s = first_valid(0);
        check("l255_len", run_len(s), 2064);
        errs = 0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            if ((s < 0) || (s + i >= do_log.size()) || (do_log[s + i] !== exp_bits[i])) errs++;
        end
        check("l255_bit_errs", errs, 0);
        check("l255_phase_errs", phase_errs(s, 255), 0);
        check("l255_accepted", accepted, 258);
        check("l255_ready_at_fe", {31'd0, rdy_at(s + 2063)}, 32'd0);
        check("l255_fe_pos", {31'd0, fe_at(s + 2063)}, 32'd1);
        check("l255_ur_count", count_ur(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/whitening_tx.md
# whitening_tx

Transmit-side PN9 whitening serializer for the packet PHY. Accepts a byte-wide frame (length byte, payload, two FCS bytes) over a valid/ready handshake and emits it LSB-first, one bit per clock. Each bit is XORed with the x^9+x^5+1 sequence. Output is gap-free for the whole frame so that the receive-side dewhitener stays in phase. Sits between the framer/FCS generator and the modulator bit interface.

## Interface
- LFSR_SEED, 9'h1FF, PN9 state loaded at frame start and whenever data_out_valid is low
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  8  frame byte from framer
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a byte this cycle
- data_out  output  1  whitened serial bit
- data_out_valid  output  1  data_out valid; high continuously for the whole frame
- out_phase  output  2  phase of the current bit: 00 idle, 01 length, 10 payload, 11 FCS
- fsc_end  output  1  one-cycle pulse with the last bit of the frame
- underrun  output  1  one-cycle pulse when a frame is aborted for lack of input

## Operation
- Frame layout: byte 0 = length L (0..255), then L payload bytes, then 2 FCS bytes, for L+3 bytes in total. The block does not generate the FCS; it whitens it like any other byte.
- Storage:
  - 1-byte holding register (hold, hold_v)
  - 8-bit shift register with a 3-bit bit counter
  - 9-bit LFSR
  - 9-bit to_accept counter (bytes of the frame not yet accepted)
- in_ready = ~hold_v AND (state == IDLE OR to_accept != 0). A transfer happens on an edge with in_valid && in_ready; it writes hold and sets hold_v.
- State machine:
  - IDLE → LEN: on an edge with hold_v set.
  - LEN → PAYLOAD: after 8 bits, if L != 0.
  - LEN → FCS: after 8 bits, if L == 0.
  - PAYLOAD → FCS: after L×8 bits.
  - FCS → IDLE: after 16 bits.
- to_accept: loaded with L+2 when the length byte moves hold→shift; decremented on each later accepted byte.
- Byte load (hold→shift): happens on the IDLE→LEN edge and on every edge ending bit 7 while more bytes remain. It clears hold_v and sets bit count 0.
- Bit output: data_out = shift bit ^ lfsr[0]. The LFSR advances as {lfsr[0]^lfsr[5], lfsr[8:1]} once per valid output bit. The LFSR is reset to LFSR_SEED in any cycle where data_out_valid is low.
- Resulting per-byte masks from the seed: FF, E1, 1D, 9A, ED, ...
- Underrun: if hold_v = 0 on the edge ending bit 7 and frame bytes remain, then on that edge:
  - data_out_valid → 0 and underrun → 1 for one cycle
  - state → IDLE, to_accept → 0
  - no fsc_end is produced
  - the next accepted byte is treated as a new length byte.
- A byte accepted on the same edge that ends bit 7 is too late and counts as an underrun.

## Timing
- All outputs except in_ready are registered.
- Reset values: data_out 0, data_out_valid 0, out_phase 00, fsc_end 0, underrun 0, in_ready 1. Internal reset: hold_v 0, state IDLE, LFSR = LFSR_SEED.
- Reset asserted mid-frame aborts immediately, with no fsc_end and no underrun pulse.
- Latency: a length byte accepted at edge k gives bit 0 valid from edge k+1.
- A frame lasts exactly 8×(L+3) consecutive data_out_valid cycles.
- Upstream has 7 cycles after each byte load (in_ready rises) to supply the next byte.
- fsc_end is high in the same cycle as bit 7 of FCS byte 2. data_out_valid falls on the following edge.
- in_ready stays low from acceptance of the last FCS byte through the fsc_end cycle.
- Back-to-back frames with in_valid held high have exactly 2 idle cycles between them.
- out_phase is aligned with data_out.

## Test plan
- L=2, bytes 02,00,00,A5,5A → whitened bytes FD,E1,1D,3F,B7, LSB-first.
  - 40 contiguous valid cycles.
  - out_phase 01×8, 10×16, 11×16.
  - fsc_end only on cycle 40.
- L=0, bytes 00,12,34 → FF,F3,29.
  - 24 valid cycles, phase 01×8 then 11×16, no 10 phase.
- Withhold the 2nd payload byte of an L=4 frame → after bit 7 of payload byte 1: data_out_valid drops, one underrun pulse, no fsc_end.
  - The following frame starts with mask FF.
- Two frames with in_valid held high → exactly 2 low data_out_valid cycles between them; the second frame's first mask is FF; in_ready low through the first fsc_end.
- Assert rst_n low during payload bit 3 → all outputs take reset values immediately; after release, an L=1 frame serializes correctly.
- L=255 with random payload → 2064 valid cycles; to_accept reaches 0 without wrap; output matches a bit-level PN9 reference model.
